// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchronizer, 4-state stability FSM, press/release strobes, glitch counter.
// Optional long-press strobe enabled with macro KEY_DEBOUNCE_LONG_PRESS_EN.
`timescale 1ns/1ps
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_raw_n,
    output logic       key_out_n,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    input  logic       glitch_clr,
    output logic [7:0] glitch_count
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] GLITCH_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    logic             q1_q, q2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_out_q, key_out_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [7:0]       glitch_q, glitch_d;
    logic             glitch_evt;

    // Next-state and output decode; the FSM only ever looks at the synchronized q2.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_out_d  = key_out_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        glitch_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (!q2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (q2_q) begin
                    state_d    = IDLE;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = PRESSED;
                    key_out_d = 1'b0;
                    press_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (q2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!q2_q) begin
                    state_d    = PRESSED;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    key_out_d = 1'b1;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear beats a coincident glitch; count saturates instead of wrapping.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q1_q      <= 1'b1;
            q2_q      <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_out_q <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            glitch_q  <= '0;
        end else begin
            q1_q      <= key_raw_n;
            q2_q      <= q1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
            glitch_q  <= glitch_d;
        end
    end

    assign key_out_n     = key_out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign glitch_count  = glitch_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [31:0] HOLD_MAX = 32'(LONG_PRESS_CYCLES);

    logic [31:0] hold_q, hold_d;
    logic        long_q, long_d;

    // Hold counter saturates at the threshold, so the strobe fires once per accepted press.
    // It is not advanced on the release-accept cycle, keeping long_press disjoint from release_pulse.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (((state_q == PRESSED) || (state_q == RELEASE_WAIT)) && !release_d
                     && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 32'd1;
            long_d = (hold_q == (HOLD_MAX - 32'd1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized bouncing
// checked against a run-length reference model.
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int D  = 4;
    localparam int LP = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_raw_n;
    logic       glitch_clr;
    logic       key_out_n;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] glitch_count;

    int n_checks = 0;
    int n_fail   = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_raw_n    (key_raw_n),
        .key_out_n    (key_out_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .glitch_clr   (glitch_clr),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    // Reference model: raw delayed two edges; output flips after D+1 consecutive
    // samples of the opposite level; an interrupted run is one glitch.
    logic m_h1, m_h2, m_seen, m_prev, m_glitch;
    logic m_out, m_press, m_rel, m_long;
    int   m_run, m_gcnt;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    int   m_held;
`endif

    always @(posedge clk) begin
        if (reset) begin
            m_h1 = 1'b1; m_h2 = 1'b1; m_out = 1'b1; m_run = 0;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_gcnt = 0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            m_held = 0;
`endif
        end else begin
            m_seen = m_h2; m_h2 = m_h1; m_h1 = key_raw_n;
            m_prev = m_out; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_glitch = 1'b0;
            if (m_seen != m_out) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_out = m_seen;
                    m_run = 0;
                    if (m_seen == 1'b0) m_press = 1'b1;
                    else m_rel = 1'b1;
                end
            end else begin
                if (m_run > 0) m_glitch = 1'b1;
                m_run = 0;
            end
            if (glitch_clr) m_gcnt = 0;
            else if (m_glitch && m_gcnt < 255) m_gcnt++;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            if (m_press) m_held = 0;
            else if (m_prev == 1'b0 && m_out == 1'b0 && m_held < LP) begin
                m_held++;
                if (m_held == LP) m_long = 1'b1;
            end
`endif
        end
    end

    task automatic cyc(input logic raw);
        key_raw_n = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; key_raw_n = 1'b1; glitch_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) cyc(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; key_raw_n = 1'b0; glitch_clr = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (key_out_n !== 1'b1) begin n_fail++; $display("FAIL reset_key_out: got %b want 1", key_out_n); end
        n_checks++;
        if ({press_pulse, release_pulse, long_press} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000", {press_pulse, release_pulse, long_press});
        end
        n_checks++;
        if (glitch_count !== 8'd0) begin n_fail++; $display("FAIL reset_glitch: got %0d want 0", glitch_count); end
        reset = 1'b0;
    endtask

    task automatic test_press_latency();
        logic exp_key, exp_p;
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            cyc(1'b0);
            exp_key = (e >= 7) ? 1'b0 : 1'b1;
            exp_p   = (e == 7);
            n_checks++;
            if (key_out_n !== exp_key) begin
                n_fail++; $display("FAIL press_latency_key edge %0d: got %b want %b", e, key_out_n, exp_key);
            end
            n_checks++;
            if (press_pulse !== exp_p) begin
                n_fail++; $display("FAIL press_latency_pulse edge %0d: got %b want %b", e, press_pulse, exp_p);
            end
        end
    endtask

    task automatic test_short_bounce();
        int pulses = 0;
        int lows   = 0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc((i < 3) ? 1'b0 : 1'b1);
            if (press_pulse || release_pulse) pulses++;
            if (key_out_n !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin n_fail++; $display("FAIL short_bounce_key: got %0d low cycles want 0", lows); end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL short_bounce_pulse: got %0d pulses want 0", pulses); end
        n_checks++;
        if (glitch_count !== 8'd1) begin n_fail++; $display("FAIL short_bounce_glitch: got %0d want 1", glitch_count); end
    endtask

    task automatic test_release_glitch();
        int rels = 0;
        do_reset();
        repeat (10) cyc(1'b0);
        cyc(1'b1); if (release_pulse) rels++;
        cyc(1'b1); if (release_pulse) rels++;
        cyc(1'b0); if (release_pulse) rels++;
        for (int e = 1; e <= 10; e++) begin
            cyc(1'b1);
            if (release_pulse) rels++;
            if (e == 6 || e == 7) begin
                n_checks++;
                if (key_out_n !== ((e == 7) ? 1'b1 : 1'b0)) begin
                    n_fail++; $display("FAIL release_glitch_key edge %0d: got %b want %b", e, key_out_n, (e == 7));
                end
            end
        end
        n_checks++;
        if (rels != 1) begin n_fail++; $display("FAIL release_glitch_pulses: got %0d want 1", rels); end
        n_checks++;
        if (glitch_count !== 8'd1) begin n_fail++; $display("FAIL release_glitch_count: got %0d want 1", glitch_count); end
    endtask

    task automatic test_glitch_saturate();
        int wraps = 0;
        logic [7:0] prev = 8'd0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0);
            if (glitch_count < prev) wraps++;
            prev = glitch_count;
            cyc(1'b1);
            if (glitch_count < prev) wraps++;
            prev = glitch_count;
        end
        n_checks++;
        if (wraps != 0) begin n_fail++; $display("FAIL glitch_wrap: got %0d decreases want 0", wraps); end
        n_checks++;
        if (glitch_count !== 8'd255) begin n_fail++; $display("FAIL glitch_saturate: got %0d want 255", glitch_count); end
        cyc(1'b0);
        glitch_clr = 1'b1;
        cyc(1'b1);
        glitch_clr = 1'b0;
        n_checks++;
        if (glitch_count !== 8'd0) begin n_fail++; $display("FAIL glitch_clr_wins: got %0d want 0", glitch_count); end
    endtask

    task automatic test_long_press();
        int p_edge = -1;
        int l_edge = -1;
        int longs  = 0;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            cyc(1'b0);
            if (press_pulse) p_edge = e;
            if (long_press) begin longs++; l_edge = e; end
        end
        for (int e = 0; e < 15; e++) begin
            cyc(1'b1);
            if (long_press) longs++;
        end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        n_checks++;
        if (longs != 1) begin n_fail++; $display("FAIL long_press_count: got %0d want 1", longs); end
        n_checks++;
        if (l_edge - p_edge != LP) begin
            n_fail++; $display("FAIL long_press_delay: got %0d want %0d", l_edge - p_edge, LP);
        end
`else
        n_checks++;
        if (longs != 0) begin n_fail++; $display("FAIL long_press_disabled: got %0d want 0", longs); end
`endif
    endtask

    task automatic test_reset_mid_press();
        int p_edge = -1;
        int rels   = 0;
        do_reset();
        repeat (12) cyc(1'b0);
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b0;
        n_checks++;
        if (key_out_n !== 1'b1) begin n_fail++; $display("FAIL reset_mid_key: got %b want 1", key_out_n); end
        n_checks++;
        if (release_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_mid_release: got %b want 0", release_pulse); end
        for (int e = 1; e <= 10; e++) begin
            cyc(1'b0);
            if (press_pulse && p_edge < 0) p_edge = e;
            if (release_pulse) rels++;
        end
        n_checks++;
        if (p_edge != 7) begin n_fail++; $display("FAIL reset_mid_requalify: got edge %0d want 7", p_edge); end
        n_checks++;
        if (rels != 0) begin n_fail++; $display("FAIL reset_mid_no_release: got %0d want 0", rels); end
    endtask

    task automatic test_random();
        logic lvl = 1'b1;
        int   left = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = (($urandom % 6) == 0) ? int'($urandom_range(10, 25)) : int'($urandom_range(1, 7));
            end
            left--;
            glitch_clr = (($urandom % 60) == 0);
            reset      = (($urandom % 500) == 0);
            cyc(lvl);
            reset = 1'b0; glitch_clr = 1'b0;
            n_checks++;
            if (key_out_n !== m_out) begin n_fail++; $display("FAIL rnd_key cyc %0d: got %b want %b", i, key_out_n, m_out); end
            n_checks++;
            if (press_pulse !== m_press) begin n_fail++; $display("FAIL rnd_press cyc %0d: got %b want %b", i, press_pulse, m_press); end
            n_checks++;
            if (release_pulse !== m_rel) begin n_fail++; $display("FAIL rnd_release cyc %0d: got %b want %b", i, release_pulse, m_rel); end
            n_checks++;
            if (long_press !== m_long) begin n_fail++; $display("FAIL rnd_long cyc %0d: got %b want %b", i, long_press, m_long); end
            n_checks++;
            if (glitch_count !== 8'(m_gcnt)) begin n_fail++; $display("FAIL rnd_glitch cyc %0d: got %0d want %0d", i, glitch_count, m_gcnt); end
            n_checks++;
            if (int'(press_pulse) + int'(release_pulse) + int'(long_press) > 1) begin
                n_fail++; $display("FAIL rnd_pulse_overlap cyc %0d: got %b want at most one", i,
                                   {press_pulse, release_pulse, long_press});
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; key_raw_n = 1'b1; glitch_clr = 1'b0;
        test_reset();
        test_press_latency();
        test_short_bounce();
        test_release_glitch();
        test_glitch_saturate();
        test_long_press();
        test_reset_mid_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
